// File: rtl/time_nmr_end.sv
// Time-redundant voter: collects Redundancy copies of each ID-tagged item, votes,
// and forwards one result per group; enable_i=0 turns the block into a plain register slice.
module time_nmr_end #(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned IDSize      = 5,
    parameter int unsigned Redundancy  = 3,
    parameter int unsigned LockTimeout = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic [IDSize-1:0]    id_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 lock_o,
    output logic                 fault_detected_o,
    output logic                 uncorrectable_o
);

    localparam int unsigned TmoW = $clog2(LockTimeout + 1);

    if (Redundancy != 2 && Redundancy != 3) begin : g_bad_redundancy
        $error("time_nmr_end: Redundancy must be 2 or 3");
    end

    logic                 out_vld_q, out_vld_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;
    logic                 b0_vld_q, b0_vld_d, b1_vld_q, b1_vld_d;
    logic [IDSize-1:0]    b0_id_q, b0_id_d, b1_id_q, b1_id_d;
    logic [DataWidth-1:0] b0_data_q, b0_data_d, b1_data_q, b1_data_d;
    logic                 last_vld_q, last_vld_d;
    logic [IDSize-1:0]    last_id_q, last_id_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [IDSize-1:0]    grp_id_q, grp_id_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic                 fault_q, fault_d;
    logic                 unc_q, unc_d;

    logic                 acc, tmo_hit;
    logic                 m_x_b0, m_x_b1, m_b0_b1;
    logic                 res_vld, emit, win_fault, pair_fault;
    logic [IDSize-1:0]    res_id;
    logic [DataWidth-1:0] res_data;

    assign ready_o = ~out_vld_q | ready_i;
    assign acc     = valid_i & ready_o;
    assign lock_o  = enable_i & (cnt_q != 2'd0);
    assign tmo_hit = lock_o & (tmo_q == TmoW'(LockTimeout - 1));

    assign m_x_b0  = b0_vld_q & (id_i == b0_id_q) & (data_i == b0_data_q);
    assign m_x_b1  = (Redundancy == 3) & b1_vld_q & (id_i == b1_id_q) & (data_i == b1_data_q);
    assign m_b0_b1 = (Redundancy == 3) & b0_vld_q & b1_vld_q
                     & (b0_id_q == b1_id_q) & (b0_data_q == b1_data_q);

    assign res_vld  = m_x_b0 | m_x_b1 | m_b0_b1;
    assign res_id   = (m_x_b0 | m_x_b1) ? id_i : b0_id_q;
    assign res_data = (m_x_b0 | m_x_b1) ? data_i : b0_data_q;
    assign emit     = acc & enable_i & res_vld & (~last_vld_q | (res_id != last_id_q));

    // A corrected window: all three copies share the id but at least one disagrees.
    assign win_fault  = (Redundancy == 3) & b0_vld_q & b1_vld_q & (id_i == b0_id_q)
                        & (id_i == b1_id_q) & ~(m_x_b0 & m_x_b1);
    assign pair_fault = (Redundancy == 2) & b0_vld_q & (id_i == b0_id_q) & (data_i != b0_data_q);

    always_comb begin
        logic [1:0] cnt_base;
        logic [1:0] cnt_inc;
        out_vld_d  = out_vld_q & ~ready_i;
        out_data_d = out_data_q;
        b0_vld_d   = b0_vld_q;
        b0_id_d    = b0_id_q;
        b0_data_d  = b0_data_q;
        b1_vld_d   = b1_vld_q;
        b1_id_d    = b1_id_q;
        b1_data_d  = b1_data_q;
        last_vld_d = last_vld_q;
        last_id_d  = last_id_q;
        cnt_d      = cnt_q;
        grp_id_d   = grp_id_q;
        tmo_d      = lock_o ? tmo_q + TmoW'(1) : '0;
        fault_d    = 1'b0;
        unc_d      = 1'b0;
        cnt_base   = cnt_q;
        cnt_inc    = 2'd0;
        if (!enable_i) begin
            b0_vld_d   = 1'b0;
            b1_vld_d   = 1'b0;
            last_vld_d = 1'b0;
            cnt_d      = 2'd0;
            if (acc) begin
                out_vld_d  = 1'b1;
                out_data_d = data_i;
            end
        end else begin
            // Timeout closes the group first so a coincident accept opens a fresh one.
            if (tmo_hit) begin
                cnt_base = 2'd0;
                tmo_d    = '0;
                fault_d  = 1'b1;
                unc_d    = ~(last_vld_q & (last_id_q == grp_id_q));
            end
            if (acc) begin
                b1_vld_d  = b0_vld_q;
                b1_id_d   = b0_id_q;
                b1_data_d = b0_data_q;
                b0_vld_d  = 1'b1;
                b0_id_d   = id_i;
                b0_data_d = data_i;
                if (emit) begin
                    out_vld_d  = 1'b1;
                    out_data_d = res_data;
                    last_vld_d = 1'b1;
                    last_id_d  = res_id;
                end
                fault_d = fault_d | (emit & win_fault) | pair_fault;
                if ((cnt_base != 2'd0) && (id_i != grp_id_q)) begin
                    unc_d = unc_d | ~((last_vld_q & (last_id_q == grp_id_q))
                                      | (emit & (res_id == grp_id_q)));
                end
                cnt_inc = ((cnt_base == 2'd0) || (id_i != grp_id_q)) ? 2'd1 : cnt_base + 2'd1;
                if (cnt_inc == 2'(Redundancy)) begin
                    cnt_d = 2'd0;
                    unc_d = unc_d | ~((last_vld_q & (last_id_q == id_i))
                                      | (emit & (res_id == id_i)));
                end else begin
                    cnt_d = cnt_inc;
                end
                grp_id_d = id_i;
            end else begin
                cnt_d = cnt_base;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            b0_vld_q   <= 1'b0;
            b0_id_q    <= '0;
            b0_data_q  <= '0;
            b1_vld_q   <= 1'b0;
            b1_id_q    <= '0;
            b1_data_q  <= '0;
            last_vld_q <= 1'b0;
            last_id_q  <= '0;
            cnt_q      <= 2'd0;
            grp_id_q   <= '0;
            tmo_q      <= '0;
            fault_q    <= 1'b0;
            unc_q      <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            b0_vld_q   <= b0_vld_d;
            b0_id_q    <= b0_id_d;
            b0_data_q  <= b0_data_d;
            b1_vld_q   <= b1_vld_d;
            b1_id_q    <= b1_id_d;
            b1_data_q  <= b1_data_d;
            last_vld_q <= last_vld_d;
            last_id_q  <= last_id_d;
            cnt_q      <= cnt_d;
            grp_id_q   <= grp_id_d;
            tmo_q      <= tmo_d;
            fault_q    <= fault_d;
            unc_q      <= unc_d;
        end
    end

    assign valid_o          = out_vld_q;
    assign data_o           = out_data_q;
    assign fault_detected_o = fault_q;
    assign uncorrectable_o  = unc_q;

endmodule

// File: tb/tb_time_nmr_end.sv
// Bench for time_nmr_end: one Redundancy=3 and one Redundancy=2 instance, expected
// outputs queued at stimulus time and compared when the output handshake happens.
module tb_time_nmr_end;

    logic clk = 1'b0;
    logic rst_n;

    logic       en3, vi3, rdy3, ro3, vo3, lk3, fd3, uc3;
    logic [7:0] di3, do3;
    logic [4:0] ii3;
    logic       en2, vi2, rdy2, ro2, vo2, lk2, fd2, uc2;
    logic [7:0] di2, do2;
    logic [4:0] ii2;

    time_nmr_end #(.DataWidth(8), .IDSize(5), .Redundancy(3), .LockTimeout(5)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en3),
        .data_i(di3), .id_i(ii3), .valid_i(vi3), .ready_o(ro3),
        .data_o(do3), .valid_o(vo3), .ready_i(rdy3),
        .lock_o(lk3), .fault_detected_o(fd3), .uncorrectable_o(uc3)
    );

    time_nmr_end #(.DataWidth(8), .IDSize(5), .Redundancy(2), .LockTimeout(5)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en2),
        .data_i(di2), .id_i(ii2), .valid_i(vi2), .ready_o(ro2),
        .data_o(do2), .valid_o(vo2), .ready_i(rdy2),
        .lock_o(lk2), .fault_detected_o(fd2), .uncorrectable_o(uc2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int f3 = 0, u3 = 0, f2 = 0, u2 = 0;
    logic [7:0] q3[$];
    logic [7:0] q2[$];
    logic [7:0] exp3, exp2;

    // Output handshake at the next rising edge is visible here; pulses are counted too.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fd3) f3++;
            if (uc3) u3++;
            if (fd2) f2++;
            if (uc2) u2++;
            if (vo3 && rdy3) begin
                n_checks++;
                if (q3.size() == 0) begin
                    n_fail++;
                    $display("FAIL out3_unexpected got=%h exp=none", do3);
                end else begin
                    exp3 = q3.pop_front();
                    if (do3 !== exp3) begin
                        n_fail++;
                        $display("FAIL out3_data got=%h exp=%h", do3, exp3);
                    end
                end
            end
            if (vo2 && rdy2) begin
                n_checks++;
                if (q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL out2_unexpected got=%h exp=none", do2);
                end else begin
                    exp2 = q2.pop_front();
                    if (do2 !== exp2) begin
                        n_fail++;
                        $display("FAIL out2_data got=%h exp=%h", do2, exp2);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive3(input logic [4:0] id, input logic [7:0] d);
        ii3 = id; di3 = d; vi3 = 1'b1;
        @(posedge clk);
        #1;
        vi3 = 1'b0;
    endtask

    task automatic drive2(input logic [4:0] id, input logic [7:0] d);
        ii2 = id; di2 = d; vi2 = 1'b1;
        @(posedge clk);
        #1;
        vi2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en3 = 1'b1; vi3 = 1'b0; rdy3 = 1'b1; di3 = '0; ii3 = '0;
        en2 = 1'b1; vi2 = 1'b0; rdy2 = 1'b1; di2 = '0; ii2 = '0;
        cycles(2);
        n_checks++;
        if ({vo3, lk3, fd3, uc3, ro3, do3} !== {5'b00001, 8'h00}) begin
            n_fail++;
            $display("FAIL reset3 got=%b exp=%b", {vo3, lk3, fd3, uc3, ro3, do3}, {5'b00001, 8'h00});
        end
        n_checks++;
        if ({vo2, lk2, fd2, uc2, ro2, do2} !== {5'b00001, 8'h00}) begin
            n_fail++;
            $display("FAIL reset2 got=%b exp=%b", {vo2, lk2, fd2, uc2, ro2, do2}, {5'b00001, 8'h00});
        end
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_r2();
        int f0 = f2, u0 = u2;
        drive2(5'd1, 8'h3C);
        drive2(5'd1, 8'h3D);
        n_checks++;
        if (vo2 !== 1'b0) begin n_fail++; $display("FAIL r2_mismatch_valid got=%b exp=0", vo2); end
        cycles(2);
        n_checks++;
        if (f2 - f0 !== 1) begin n_fail++; $display("FAIL r2_fault got=%0d exp=1", f2 - f0); end
        n_checks++;
        if (u2 - u0 !== 1) begin n_fail++; $display("FAIL r2_unc got=%0d exp=1", u2 - u0); end
        q2.push_back(8'h5A);
        drive2(5'd2, 8'h5A);
        drive2(5'd2, 8'h5A);
        n_checks++;
        if ({vo2, do2} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL r2_match_out got=%h exp=15a", {vo2, do2}); end
        cycles(2);
        n_checks++;
        if ((f2 - f0 !== 1) || (u2 - u0 !== 1)) begin
            n_fail++;
            $display("FAIL r2_match_pulses got=%0d/%0d exp=1/1", f2 - f0, u2 - u0);
        end
    endtask

    task automatic test_triple();
        int f0 = f3, u0 = u3;
        drive3(5'd3, 8'hA5);
        n_checks++;
        if ({lk3, vo3} !== 2'b10) begin n_fail++; $display("FAIL triple_copy1 got=%b exp=10", {lk3, vo3}); end
        q3.push_back(8'hA5);
        drive3(5'd3, 8'hA5);
        n_checks++;
        if ({lk3, vo3, do3} !== {2'b11, 8'hA5}) begin
            n_fail++;
            $display("FAIL triple_latency got=%b exp=%b", {lk3, vo3, do3}, {2'b11, 8'hA5});
        end
        drive3(5'd3, 8'hA5);
        n_checks++;
        if ({lk3, vo3} !== 2'b00) begin n_fail++; $display("FAIL triple_copy3 got=%b exp=00", {lk3, vo3}); end
        cycles(3);
        n_checks++;
        if ((f3 - f0 !== 0) || (u3 - u0 !== 0)) begin
            n_fail++;
            $display("FAIL triple_pulses got=%0d/%0d exp=0/0", f3 - f0, u3 - u0);
        end
    endtask

    task automatic test_corrected();
        int f0 = f3, u0 = u3;
        drive3(5'd4, 8'hA5);
        drive3(5'd4, 8'h5A);
        n_checks++;
        if (vo3 !== 1'b0) begin n_fail++; $display("FAIL corr_early got=%b exp=0", vo3); end
        q3.push_back(8'hA5);
        drive3(5'd4, 8'hA5);
        n_checks++;
        if ({vo3, do3} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL corr_out got=%h exp=1a5", {vo3, do3}); end
        cycles(3);
        n_checks++;
        if ((f3 - f0 !== 1) || (u3 - u0 !== 0)) begin
            n_fail++;
            $display("FAIL corr_pulses got=%0d/%0d exp=1/0", f3 - f0, u3 - u0);
        end
    endtask

    task automatic test_uncorrectable();
        int f0 = f3, u0 = u3;
        drive3(5'd7, 8'h11);
        drive3(5'd7, 8'h22);
        drive3(5'd7, 8'h33);
        cycles(3);
        n_checks++;
        if ((f3 - f0 !== 0) || (u3 - u0 !== 1) || (lk3 !== 1'b0)) begin
            n_fail++;
            $display("FAIL uncorr_pulses got=%0d/%0d lock=%b exp=0/1 lock=0", f3 - f0, u3 - u0, lk3);
        end
    endtask

    task automatic test_timeout();
        int f0 = f3, u0 = u3;
        drive3(5'd9, 8'h42);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (lk3 !== 1'b1) begin n_fail++; $display("FAIL tmo_lock_high k=%0d got=%b exp=1", k, lk3); end
            cycles(1);
        end
        n_checks++;
        if (lk3 !== 1'b0) begin n_fail++; $display("FAIL tmo_lock_drop got=%b exp=0", lk3); end
        cycles(2);
        n_checks++;
        if ((f3 - f0 !== 1) || (u3 - u0 !== 1)) begin
            n_fail++;
            $display("FAIL tmo_pulses got=%0d/%0d exp=1/1", f3 - f0, u3 - u0);
        end
    endtask

    task automatic test_timeout_accept();
        int f0 = f3, u0 = u3;
        drive3(5'd10, 8'h66);
        cycles(4);
        q3.push_back(8'h66);
        drive3(5'd10, 8'h66);
        n_checks++;
        if ({lk3, vo3, do3} !== {2'b11, 8'h66}) begin
            n_fail++;
            $display("FAIL tmoacc_restart got=%b exp=%b", {lk3, vo3, do3}, {2'b11, 8'h66});
        end
        for (int k = 1; k < 5; k++) begin
            cycles(1);
            n_checks++;
            if (lk3 !== 1'b1) begin n_fail++; $display("FAIL tmoacc_lock k=%0d got=%b exp=1", k, lk3); end
        end
        cycles(1);
        n_checks++;
        if (lk3 !== 1'b0) begin n_fail++; $display("FAIL tmoacc_drop got=%b exp=0", lk3); end
        cycles(2);
        n_checks++;
        if ((f3 - f0 !== 2) || (u3 - u0 !== 1)) begin
            n_fail++;
            $display("FAIL tmoacc_pulses got=%0d/%0d exp=2/1", f3 - f0, u3 - u0);
        end
    endtask

    task automatic test_back_to_back();
        int f0 = f3, u0 = u3;
        q3.push_back(8'h77);
        q3.push_back(8'h88);
        drive3(5'd20, 8'h77);
        drive3(5'd21, 8'h88);
        drive3(5'd20, 8'h77);
        n_checks++;
        if ({vo3, do3} !== {1'b1, 8'h77}) begin n_fail++; $display("FAIL b2b_first got=%h exp=177", {vo3, do3}); end
        drive3(5'd21, 8'h88);
        n_checks++;
        if ({vo3, do3} !== {1'b1, 8'h88}) begin n_fail++; $display("FAIL b2b_reload got=%h exp=188", {vo3, do3}); end
        cycles(10);
        n_checks++;
        if ((f3 - f0 !== 1) || (u3 - u0 !== 2)) begin
            n_fail++;
            $display("FAIL b2b_pulses got=%0d/%0d exp=1/2", f3 - f0, u3 - u0);
        end
    endtask

    task automatic test_stall();
        int f0 = f3, u0 = u3;
        drive3(5'd22, 8'h99);
        q3.push_back(8'h99);
        drive3(5'd22, 8'h99);
        rdy3 = 1'b0;
        #1;
        n_checks++;
        if ({vo3, ro3, do3} !== {2'b10, 8'h99}) begin
            n_fail++;
            $display("FAIL stall_ready got=%b exp=%b", {vo3, ro3, do3}, {2'b10, 8'h99});
        end
        cycles(1);
        n_checks++;
        if ({vo3, do3} !== {1'b1, 8'h99}) begin n_fail++; $display("FAIL stall_hold got=%h exp=199", {vo3, do3}); end
        rdy3 = 1'b1;
        drive3(5'd22, 8'h99);
        n_checks++;
        if ({vo3, lk3} !== 2'b00) begin n_fail++; $display("FAIL stall_drain got=%b exp=00", {vo3, lk3}); end
        cycles(2);
        n_checks++;
        if ((f3 - f0 !== 0) || (u3 - u0 !== 0)) begin
            n_fail++;
            $display("FAIL stall_pulses got=%0d/%0d exp=0/0", f3 - f0, u3 - u0);
        end
    endtask

    task automatic test_switch();
        int f0 = f3, u0 = u3;
        drive3(5'd23, 8'h12);
        en3 = 1'b0;
        #1;
        n_checks++;
        if (lk3 !== 1'b0) begin n_fail++; $display("FAIL switch_lock_off got=%b exp=0", lk3); end
        cycles(1);
        en3 = 1'b1;
        #1;
        n_checks++;
        if (lk3 !== 1'b0) begin n_fail++; $display("FAIL switch_cnt_cleared got=%b exp=0", lk3); end
        cycles(1);
        drive3(5'd23, 8'h12);
        n_checks++;
        if (vo3 !== 1'b0) begin n_fail++; $display("FAIL switch_discard got=%b exp=0", vo3); end
        cycles(8);
        n_checks++;
        if ((f3 - f0 !== 1) || (u3 - u0 !== 1)) begin
            n_fail++;
            $display("FAIL switch_pulses got=%0d/%0d exp=1/1", f3 - f0, u3 - u0);
        end
    endtask

    task automatic test_reset_mid();
        int f0 = f3, u0 = u3;
        drive3(5'd24, 8'h34);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({lk3, vo3, fd3, uc3} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_async got=%b exp=0000", {lk3, vo3, fd3, uc3});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(8);
        n_checks++;
        if ((f3 - f0 !== 0) || (u3 - u0 !== 0) || (lk3 !== 1'b0)) begin
            n_fail++;
            $display("FAIL rstmid_pulses got=%0d/%0d lock=%b exp=0/0 lock=0", f3 - f0, u3 - u0, lk3);
        end
    endtask

    task automatic test_passthrough();
        int f0 = f3, u0 = u3;
        logic [7:0] d;
        logic acc;
        int budget;
        en3 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            d   = 8'($urandom);
            di3 = d;
            ii3 = 5'($urandom);
            vi3 = 1'b1;
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 50) begin
                @(negedge clk);
                acc = ro3;
                @(posedge clk);
                #1;
                rdy3 = 1'($urandom_range(0, 1));
                budget++;
            end
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL pass_accept_timeout item=%0d", i);
            end else begin
                q3.push_back(d);
            end
            vi3 = 1'b0;
            if ($urandom_range(0, 3) == 0) cycles(1);
        end
        n_checks++;
        if (lk3 !== 1'b0) begin n_fail++; $display("FAIL pass_lock got=%b exp=0", lk3); end
        rdy3 = 1'b1;
        cycles(4);
        n_checks++;
        if (q3.size() != 0) begin n_fail++; $display("FAIL pass_drain got=%0d exp=0", q3.size()); end
        n_checks++;
        if ((f3 - f0 !== 0) || (u3 - u0 !== 0)) begin
            n_fail++;
            $display("FAIL pass_pulses got=%0d/%0d exp=0/0", f3 - f0, u3 - u0);
        end
    endtask

    initial begin
        test_reset();
        test_r2();
        test_triple();
        test_corrected();
        test_uncorrectable();
        test_timeout();
        test_timeout_accept();
        test_back_to_back();
        test_stall();
        test_switch();
        test_reset_mid();
        test_passthrough();
        n_checks++;
        if (q2.size() != 0) begin n_fail++; $display("FAIL final_q2 got=%0d exp=0", q2.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_nmr_end.md
TIME_NMR_END -- requirements
Module: time_nmr_end

Interface
REQ-001 Parameters SHALL be: DataWidth, default 8, payload bits; IDSize, default 5, group-ID bits; Redundancy, default 3, copies per group (legal 2 or 3, other values rejected at elaboration); LockTimeout, default 5, maximum cycles lock_o may stay high.
REQ-002 Ports SHALL be, in order: clk_i in 1, the single clock; rst_ni in 1, reset, asynchronous and active-low.
REQ-003 enable_i in 1: 1 selects redundant voting, 0 selects pass-through.
REQ-004 data_i in DataWidth, id_i in IDSize, valid_i in 1, ready_o out 1: upstream valid/ready channel.
REQ-005 data_o out DataWidth, valid_o out 1, ready_i in 1: downstream valid/ready channel.
REQ-006 lock_o out 1: requests the upstream arbiter to hold its selection while a group is incomplete.
REQ-007 fault_detected_o out 1: one-cycle pulse on a detected or corrected fault.
REQ-008 uncorrectable_o out 1: one-cycle pulse when a group is dropped without output.

Function
REQ-009 Output stage: a single register (data_o, valid_o); ready_o = ~valid_o | ready_i; valid_o clears on a downstream handshake unless reloaded in the same cycle.
REQ-010 Accept: an upstream handshake is valid_i & ready_o; no state changes without one, except the timeout counter.
REQ-011 History buffer: Redundancy-1 entries b0 (newest) and b1, each holding valid, id and data; on an accept with enable_i=1, the input shifts into b0 and b0 shifts into b1.
REQ-012 Match: x~e means e is valid, id_x==id_e and data_x==data_e.
REQ-013 Vote for Redundancy=3 on each accept of x: x~b0 or x~b1 gives result x; else b0~b1 gives result b0; else no result.
REQ-014 Vote for Redundancy=2: x~b0 gives result x; else no result.
REQ-015 Emission: a result loads the output register 1 cycle after the accept (latency 1) only if last_vld=0 or result id != last_id; it then sets last_id=result id and last_vld=1; otherwise the result is suppressed.
REQ-016 Group counter cnt (0..Redundancy-1): on accept, cnt becomes 1 if id_x != grp_id or cnt=0, otherwise it increments; grp_id takes id_x; when the counter would reach Redundancy, cnt returns to 0.
REQ-017 lock_o = enable_i & (cnt != 0).
REQ-018 Timeout counter: counts cycles with lock_o=1 and clears when lock_o=0; on reaching LockTimeout it forces cnt=0 and pulses fault_detected_o next cycle.
REQ-019 fault_detected_o SHALL pulse the cycle after an emission where the window (x, b0, b1) was not fully matching while sharing one id.
REQ-020 fault_detected_o SHALL also pulse for Redundancy=2 when id_x==id_b0 but data differs.
REQ-021 uncorrectable_o SHALL pulse when a group closes (cnt wraps to 0, a new id starts, or timeout) and its id was never emitted.
REQ-022 Simultaneous events: an emission and a downstream handshake in one cycle reload the register (valid_o stays 1); a timeout coinciding with an accept applies the accept after the timeout clear, so the new item starts cnt=1.
REQ-023 Pass-through (enable_i=0): every accept loads the output register directly; the buffer valids, last_vld and cnt are cleared; lock_o=0; fault outputs=0.
REQ-024 Switching enable_i mid-group discards the buffered copies, with no pulses.

Reset
REQ-025 Asynchronous reset SHALL clear valid_o, lock_o, fault_detected_o, uncorrectable_o, data_o='0, all buffer valids, last_vld, cnt and the timeout counter.
REQ-026 Reset mid-group SHALL discard the partial group without any pulse after release.

Verification
REQ-027 Redundancy=3, enable=1, ready_i=1: three copies (id 3, data 0xA5) -> one output 0xA5 one cycle after copy 2; lock_o high from copy 1 to copy 3; no fault pulse.
REQ-028 Redundancy=3: copies 0xA5, 0x5A, 0xA5 (id 4) -> output 0xA5 after copy 3; fault_detected_o pulses once.
REQ-029 Redundancy=3: copies 0x11, 0x22, 0x33 (id 7) -> no output; uncorrectable_o pulses once when the group closes.
REQ-030 LockTimeout=5: a single copy of id 9, then valid_i=0 -> lock_o drops after 5 cycles; fault_detected_o and uncorrectable_o pulse.
REQ-031 Redundancy=2: copies (id 1, 0x3C), (id 1, 0x3D) -> no output, fault_detected_o pulses; enable=0 with 100 random items and random ready_i -> every item is output in order.
